// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Result width: full signed product plus enough guard bits for N additions.
  function automatic int acc_width(input int n, input int data_width);
    return 2 * data_width + $clog2(n);
  endfunction

  // (ptr - k) mod n without relying on n being a power of two.
  function automatic int wrap_sub(input int ptr, input int k, input int n);
    return (ptr >= k) ? (ptr - k) : (ptr + n - k);
  endfunction

endpackage

// File: rtl/fir_tap_mac.sv
// Registered signed multiply-accumulate; the sequencer supplies operands and control.
module fir_tap_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [DATA_WIDTH-1:0] coeff,
  output logic signed [ACC_WIDTH-1:0]  acc_next
);

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_d;

  assign product     = sample * coeff;
  assign product_ext = {{(ACC_WIDTH - 2 * DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
  assign acc_next    = acc_q + product_ext;

  // Clear wins over accumulate; otherwise the running sum is held.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_next;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// N-tap FIR computed one tap per cycle on a single shared MAC.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ACC_WIDTH  = acc_width(N, DATA_WIDTH),
  localparam int AW         = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [AW-1:0]                cfg_addr,
  input  logic signed [DATA_WIDTH-1:0] cfg_data,
  output logic                         cfg_ready,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  y_out,
  output logic                         busy
);

  state_e                      state_q, state_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               tap_q, tap_d;
  logic signed [DATA_WIDTH-1:0] sample_q [N];
  logic signed [DATA_WIDTH-1:0] sample_d [N];
  logic signed [DATA_WIDTH-1:0] coeff_q  [N];
  logic signed [DATA_WIDTH-1:0] coeff_d  [N];
  logic                        out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] y_out_q, y_out_d;

  logic                        mac_clr;
  logic                        mac_en;
  logic [AW-1:0]               rd_idx;
  logic signed [ACC_WIDTH-1:0] mac_sum;

  // Tap k pairs coeff[k] with the sample written k acceptances ago.
  assign rd_idx    = AW'(wrap_sub(int'(wr_ptr_q), int'(tap_q), N));

  assign cfg_ready = (state_q == IDLE);
  assign in_ready  = (state_q == IDLE) && !cfg_we && !flush;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign y_out     = y_out_q;

  fir_tap_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .sample  (sample_q[rd_idx]),
    .coeff   (coeff_q[tap_q]),
    .acc_next(mac_sum)
  );

  // Sequencer next-state: config and flush only act while idle, config first.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    tap_d       = tap_q;
    sample_d    = sample_q;
    coeff_d     = coeff_q;
    out_valid_d = out_valid_q;
    y_out_d     = y_out_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          if (int'(cfg_addr) < N) begin
            coeff_d[cfg_addr] = cfg_data;
          end
        end else if (flush) begin
          for (int i = 0; i < N; i++) begin
            sample_d[i] = '0;
          end
          wr_ptr_d = '0;
        end else if (in_valid) begin
          sample_d[wr_ptr_q] = x_in;
          tap_d              = '0;
          mac_clr            = 1'b1;
          state_d            = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap_q == AW'(N - 1)) begin
          tap_d       = '0;
          y_out_d     = mac_sum;
          out_valid_d = 1'b1;
          wr_ptr_d    = (wr_ptr_q == AW'(N - 1)) ? '0 : wr_ptr_q + AW'(1);
          state_d     = OUT;
        end else begin
          tap_d = tap_q + AW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // All sequencer state, buffers and registered outputs; reset abandons any work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      tap_q       <= '0;
      out_valid_q <= 1'b0;
      y_out_q     <= '0;
      for (int i = 0; i < N; i++) begin
        sample_q[i] <= '0;
        coeff_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      tap_q       <= tap_d;
      out_valid_q <= out_valid_d;
      y_out_q     <= y_out_d;
      sample_q    <= sample_d;
      coeff_q     <= coeff_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer (N=4, 8-bit data, 18-bit result).
module tb_fir_mac_sequencer;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 2;

   logic                  clk;
   logic                  rst_n;
   logic                  cfg_we;
   logic [AW-1:0]         cfg_addr;
   logic signed [DW-1:0]  cfg_data;
   logic                  cfg_ready;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic signed [DW-1:0]  x_in;
   logic                  out_valid;
   logic                  out_ready;
   logic signed [17:0]    y_out;
   logic                  busy;

   int compareCount;
   int mismatchCount;
   int sb[$];
   int modelCoeff[N];
   int modelHist[N];

   fir_mac_sequencer #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .cfg_ready(cfg_ready),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_in     (x_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y_out    (y_out),
      .busy     (busy)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges despite the bounded waits.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference convolution: newest sample sits at modelHist[0].
   task automatic pushExpected(input int x);
      int acc;
      acc = 0;
      for (int i = N - 1; i > 0; i--) modelHist[i] = modelHist[i-1];
      modelHist[0] = x;
      for (int k = 0; k < N; k++) acc += modelHist[k] * modelCoeff[k];
      sb.push_back(acc);
   endtask

   task automatic clearModel();
      for (int i = 0; i < N; i++) begin
         modelHist[i]  = 0;
         modelCoeff[i] = 0;
      end
      sb.delete();
   endtask

   // Every completed output handshake is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_out", 1, 0);
         end else begin
            checkOutput("y_out", int'(y_out), sb.pop_front());
         end
      end
   end

   // All driving tasks start and end at posedge+1.
   task automatic applyStimulus(input int x);
      bit accepted;
      accepted = 0;
      in_valid = 1'b1;
      x_in     = DW'(x);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (in_ready) begin
            pushExpected(x);
            accepted = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!accepted) checkOutput("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic writeCoeff(input int addr, input int data);
      cfg_we   = 1'b1;
      cfg_addr = AW'(addr);
      cfg_data = DW'(data);
      @(negedge clk);
      checkOutput("cfg_ready", int'(cfg_ready), 1);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      modelCoeff[addr] = data;
   endtask

   task automatic doFlush();
      flush = 1'b1;
      @(negedge clk);
      checkOutput("flush_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      flush = 1'b0;
      for (int i = 0; i < N; i++) modelHist[i] = 0;
   endtask

   task automatic waitDrain();
      bit done;
      done = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         checkOutput("drain_timeout", 0, 1);
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int seen;
      compareCount  = 0;
      mismatchCount = 0;
      rst_n     = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      x_in      = '0;
      out_ready = 1'b1;
      clearModel();

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_y_out", int'(y_out), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_in_ready", int'(in_ready), 1);
      checkOutput("rst_cfg_ready", int'(cfg_ready), 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset asserted in the middle of a MAC run
      for (int k = 0; k < N; k++) writeCoeff(k, k + 1);
      applyStimulus(9);
      @(posedge clk); #1;
      checkOutput("mid_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", int'(out_valid), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_in_ready", int'(in_ready), 1);
      clearModel();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("postrst_out_valid", int'(out_valid), 0);

      // Impulse then step response, coeffs {1,2,3,4}
      for (int k = 0; k < N; k++) writeCoeff(k, k + 1);
      applyStimulus(1);
      for (int i = 0; i < 4; i++) applyStimulus(0);
      waitDrain();
      for (int i = 0; i < 4; i++) applyStimulus(5);
      waitDrain();

      // Backpressure: result held while the sink stalls, next sample waits
      out_ready = 1'b0;
      applyStimulus(2);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      checkOutput("bp_out_valid_seen", seen, 1);
      @(posedge clk); #1;
      in_valid = 1'b1;
      x_in     = DW'(3);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (sb.size() > 0) checkOutput("bp_hold_y", int'(y_out), sb[0]);
         checkOutput("bp_in_ready", int'(in_ready), 0);
         checkOutput("bp_out_valid", int'(out_valid), 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("bp_resume_ready", int'(in_ready), 1);
      pushExpected(3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitDrain();

      // Extremes: all -128 must reach 65536 without wrapping
      for (int k = 0; k < N; k++) writeCoeff(k, -128);
      for (int i = 0; i < 4; i++) applyStimulus(-128);
      waitDrain();
      checkOutput("extreme_hold", int'(y_out), 65536);

      // Priority: config beats a sample in the same cycle; flush clears history
      for (int k = 0; k < 3; k++) writeCoeff(k, k + 1);
      doFlush();
      cfg_we   = 1'b1;
      cfg_addr = AW'(3);
      cfg_data = DW'(4);
      in_valid = 1'b1;
      x_in     = DW'(7);
      @(negedge clk);
      checkOutput("prio_in_ready", int'(in_ready), 0);
      checkOutput("prio_cfg_ready", int'(cfg_ready), 1);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      modelCoeff[3] = 4;
      @(negedge clk);
      checkOutput("prio_accept", int'(in_ready), 1);
      pushExpected(7);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(0);
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
